bcd_seg_scan: RTL

Time-multiplexed seven-segment display driver that sits directly downstream of the shift-add multiplier `mul`. It captures the multiplier's packed BCD result on the rising edge of `finish` and holds it. It then scans the digits one at a time onto a common segment bus with per-digit anode enables, blanking leading zeros. It contains all display state; the multiplier needs no changes.

---
 rtl/bcd_seg_scan.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
//
// Time-multiplexed seven-segment display driver for the packed BCD result of
// the shift-add multiplier. The value is captured on the rising edge of the
// multiplier's finish strobe and then held. A prescaler steps a digit index
// that scans the held digits one at a time onto a shared segment bus. Leading
// zeros are blanked, except that the least significant digit is always shown.
//
// Parameters
//   DIGITS       number of BCD digits on bcd_in and anode enables on an
//   REFRESH_DIV  clock cycles each digit stays enabled (>= 1)
//
// Ports
//   clk     in   single clock; all state updates on the rising edge
//   reset   in   asynchronous, active-high; clears all state immediately
//   bcd_in  in   packed BCD, digit k at [4k+3:4k], digit 0 least significant
//   load    in   capture strobe; only its rising edge matters
//   seg     out  active-low segments {g,f,e,d,c,b,a}
//   an      out  active-low digit enables; one low bit or all high
//   valid   out  high once a value has been captured since reset
// -----------------------------------------------------------------------------
module bcd_seg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGITS*4-1:0] bcd_in,
    input  logic                load,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                valid
);

    // Counter widths are kept at least one bit wide, so that REFRESH_DIV=1
    // and DIGITS=1 still elaborate.
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // -------------------------------------------------------------------------
    // Segment decode (active-low). Nibbles A-F show a dash so that a corrupt
    // digit is visible on the display and is not mistaken for a number.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                load_q;
    logic [DIGITS*4-1:0] value_q,  value_d;
    logic [DIGITS-1:0]   blank_q,  blank_d;
    logic                valid_q,  valid_d;
    logic [PW-1:0]       presc_q,  presc_d;
    logic [IW-1:0]       idx_q,    idx_d;
    logic [6:0]          seg_q,    seg_d;
    logic [DIGITS-1:0]   an_q,     an_d;

    logic                capture;
    logic                presc_wrap;
    logic [DIGITS-1:0]   blank_new;
    logic [3:0]          cur_nib;
    logic                cur_blank;

    // A capture happens on the first cycle that load is seen high. Holding load
    // high does not capture again. After reset load_q is 0, so a load that is
    // already high at reset release captures on the first edge.
    assign capture = load & ~load_q;

    // -------------------------------------------------------------------------
    // Leading-zero blank mask of the incoming value. Digit k (k >= 1) is
    // blanked when it and every higher digit are zero. Nibbles A-F count as
    // nonzero. Digit 0 is never blanked.
    // -------------------------------------------------------------------------
    always_comb begin
        logic nz_above;
        // NOTE: every signal written in always_comb gets a default first, so
        // that no path leaves it unassigned and no latch is inferred.
        blank_new = '0;
        nz_above  = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nz_above     = nz_above | (bcd_in[4*k +: 4] != 4'd0);
            blank_new[k] = ~nz_above;
        end
    end

    // -------------------------------------------------------------------------
    // Capture path
    // -------------------------------------------------------------------------
    always_comb begin
        value_d = value_q;
        blank_d = blank_q;
        valid_d = valid_q;
        if (capture) begin
            value_d = bcd_in;
            blank_d = blank_new;
            valid_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler and digit index. These run freely and do not depend on
    // capture, so a new value never disturbs the scan phase.
    // -------------------------------------------------------------------------
    assign presc_wrap = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_wrap) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Digit selection for the output register. The select loop keeps the
    // index compare explicit, so index values beyond DIGITS-1 (possible when
    // DIGITS is not a power of two) read as blanked.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = value_q[4*k +: 4];
                cur_blank = blank_q[k];
            end
        end
    end

    // The output register is fed from the registered index and value, so
    // seg/an lag the scan state by one cycle and leave the block glitch-free.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        if (valid_q && !cur_blank) begin
            seg_d = seg_decode(cur_nib);
            an_d  = ~(DIGITS'(1) << idx_q);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge regardless of the
        // order of the statements.
        if (reset) begin
            load_q  <= 1'b0;
            value_q <= '0;
            blank_q <= '1;
            valid_q <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
        end else begin
            load_q  <= load;
            value_q <= value_d;
            blank_q <= blank_d;
            valid_q <= valid_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign valid = valid_q;

endmodule
